psum_fifo: RTL
==============

PSUM_FIFO -- requirements
Module: psum_fifo

Interface
REQ-001 Parameter WIDTH, default 16: bit width of one fp16 partial-sum word.
REQ-002 Parameter DEPTH, default 16: number of storage entries, power of two.
REQ-003 Parameter GROUP, default 8: words per reduction group, equal to the leaf count of the downstream partial-sum adder tree.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port wr_en, input, 1: PE-array write strobe.
REQ-007 Port wr_data, input, WIDTH: fp16 partial sum to store.
REQ-008 Port rd_ready, input, 1: downstream accepts fifo_out this cycle.
REQ-009 Port fifo_out, output, WIDTH: head word presented to the partial-sum accumulation stage.
REQ-010 Port out_valid, output, 1: fifo_out carries a valid word.
REQ-011 Port full, output, 1: count equals DEPTH.
REQ-012 Port empty, output, 1: count equals 0.
REQ-013 Port count, output, clog2(DEPTH)+1: number of stored words.
REQ-014 Port overflow, output, 1: sticky flag for a dropped write.
REQ-015 Port group_done, output, 1: one-cycle pulse after the GROUP-th pop of a group.

Function
REQ-016 A write SHALL be accepted when wr_en=1 and full=0; wr_data SHALL be stored at wr_ptr, wr_ptr SHALL increment modulo DEPTH, and count SHALL increment.
REQ-017 wr_en=1 with full=1 SHALL drop the data and set overflow=1, even when a pop occurs in the same cycle.
REQ-018 A pop SHALL occur when out_valid=1 and rd_ready=1; rd_ptr SHALL increment modulo DEPTH and count SHALL decrement.
REQ-019 An accepted write and a pop in the same cycle SHALL leave count unchanged, and both pointers SHALL advance.
REQ-020 fifo_out SHALL equal mem[rd_ptr] while out_valid=1 and SHALL equal 16'h0000 while out_valid=0.
REQ-021 First-word latency: a write accepted at edge N into an empty FIFO SHALL be visible with out_valid=1 in the cycle after edge N (in streaming mode).
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 with no data loss; full and empty SHALL be derived from count, not from pointer comparison.
REQ-023 A beat counter (0..GROUP-1) SHALL increment on each pop and wrap to 0 on the GROUP-th pop; group_done SHALL be 1 for exactly one cycle, the cycle after that pop.
REQ-024 Read FSM states: IDLE and BURST.
REQ-025 In IDLE, out_valid SHALL be 0.
REQ-026 The FSM SHALL move from IDLE to BURST when its entry condition (REQ-034/REQ-035) holds.
REQ-027 In BURST, out_valid SHALL be 1.
REQ-028 The FSM SHALL return from BURST to IDLE on the GROUP-th pop of the group, or when count reaches 0.
REQ-029 rd_ready=0 in BURST SHALL stall with fifo_out held and the beat counter unchanged.

Reset
REQ-030 Asserting reset SHALL immediately clear wr_ptr, rd_ptr, count, the beat counter, overflow and group_done, and force the FSM to IDLE.
REQ-031 During reset, out_valid and fifo_out SHALL be 0, empty=1 and full=0.
REQ-032 Memory contents SHALL NOT be reset; reset mid-burst SHALL discard the partial group.
REQ-033 overflow SHALL be cleared only by reset.

Configuration
REQ-034 With macro PSUM_FIFO_BURST_EN defined, IDLE->BURST SHALL require count>=GROUP, so every group is delivered as GROUP back-to-back words, with at least one idle cycle between groups.
REQ-035 Without PSUM_FIFO_BURST_EN, IDLE->BURST SHALL require count>=1 (streaming); group_done SHALL still pulse every GROUP pops.

Verification
REQ-036 Burst mode: write 8 words 16'h3C00..16'h3C07 with rd_ready=1 -> out_valid rises only after the 8th write; 8 consecutive pops in order; group_done pulses once; out_valid then drops for at least 1 cycle.
REQ-037 Streaming mode: write one word 16'h4000 at edge N -> out_valid=1 and fifo_out=16'h4000 in the cycle after edge N; one pop; empty=1 and fifo_out=16'h0000.
REQ-038 Fill 16 words with rd_ready=0, then a 17th write of 16'h5555 -> full=1, overflow=1, count=16; reads return the first 16 words, and 16'h5555 never appears.
REQ-039 Pointer wrap: 40 writes interleaved with 40 pops at random rd_ready -> output order equals input order; count never exceeds 16; 5 group_done pulses.
REQ-040 Reset asserted after 3 of 8 burst pops -> count=0, out_valid=0, fifo_out=16'h0000 asynchronously; after 8 new writes, the next group_done follows exactly 8 pops.
REQ-041 Simultaneous write and pop at count=5 -> count stays 5 and data order is preserved.

Source files
------------

// File: rtl/psum_fifo.sv
// Partial-sum FIFO between the PE array and the adder tree, delivering words in reduction groups.
// Optional macro PSUM_FIFO_BURST_EN: wait for a full group before presenting any word.
module psum_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned GROUP = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         fifo_out,
  output logic                     out_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     group_done
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = (GROUP > 1) ? $clog2(GROUP) : 1;

  typedef enum logic {StIdle, StBurst} state_e;

  state_e          state_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   beat_q;
  logic            overflow_q, group_done_q;
  logic            wr_acc, pop, last_beat, enter_burst;

  always_comb begin
    wr_acc    = wr_en && !full;
    pop       = out_valid && rd_ready;
    last_beat = pop && (beat_q == BW'(GROUP - 1));
    count_d   = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Entry looks at next-state count so a word written at edge N is presented right after it.
`ifdef PSUM_FIFO_BURST_EN
    enter_burst = (count_d >= CW'(GROUP));
`else
    enter_burst = (count_d != '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beat_q       <= '0;
      overflow_q   <= 1'b0;
      group_done_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      if (wr_en && full) overflow_q <= 1'b1;
      group_done_q <= last_beat;
      if (pop) beat_q <= last_beat ? '0 : beat_q + BW'(1);
      case (state_q)
        StIdle:  if (enter_burst) state_q <= StBurst;
        StBurst: if (last_beat || count_d == '0) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    out_valid  = (state_q == StBurst);
    fifo_out   = out_valid ? mem[rd_ptr_q] : '0;
    full       = (count_q == CW'(DEPTH));
    empty      = (count_q == '0);
    count      = count_q;
    overflow   = overflow_q;
    group_done = group_done_q;
  end

endmodule
